spi_host: RTL and testbench

Wishbone-responder SPI controller (FPGA drives SCK), complementing `spi1_controller`, where the FPGA is the SPI target. It sits on the shared Wishbone bus beside the RAM bridge, register file and keyboard. It lets any Wishbone initiator run byte-wide, mode-0, MSB-first transfers to an attached SPI peripheral (e.g. SD card, expansion device). Software controls chip select and clock divider through a 4-register window.

---
 rtl/spi_host.sv | 123 ++++++++++++
 tb/tb_spi_host.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host.sv
// Wishbone-attached SPI host: byte-wide, mode 0, MSB first, software-driven chip select.
// SCK phases last DIVIDER+1 clocks; a transfer is one setup phase plus 8 high and 7 low phases.
module spi_host #(
  parameter int         WB_ADDR_WIDTH = 4,
  parameter int         DATA_WIDTH    = 8,
  parameter logic [7:0] DIV_RESET     = 8'd15
) (
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_ni,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0]    wb_data_i,
  output logic [7:0]               wb_data_o,
  input  logic                     wb_we_i,
  input  logic                     wb_cycle_i,
  input  logic                     wb_strobe_i,
  output logic                     wb_stall_o,
  output logic                     wb_ack_o,
  output logic                     spi_cs_no,
  output logic                     spi_sck_o,
  output logic                     spi_sd_o,
  input  logic                     spi_sd_i
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

  state_t      r_state, w_state_nx;
  logic [7:0]  r_cnt, r_div, r_div_q, r_tx, r_rx, r_rx_data, r_data_o;
  logic [2:0]  r_bit;
  logic        r_sck, r_ack, r_cs_en, r_rx_valid;
  logic        w_busy, w_accept, w_wr_data, w_rd_data, w_phase_end, w_bit_end, w_last;
  logic [7:0]  w_wdat, w_rd_mux, w_rx_nx;
  logic [1:0]  w_addr;
  logic        w_unused;

  assign w_unused    = ^{wb_addr_i, wb_data_i};
  assign w_addr      = wb_addr_i[1:0];
  assign w_wdat      = wb_data_i[7:0];
  assign w_busy      = (r_state != S_IDLE);
  assign wb_stall_o  = w_busy & wb_we_i & wb_cycle_i & wb_strobe_i;
  assign w_accept    = wb_cycle_i & wb_strobe_i & ~wb_stall_o;
  assign w_wr_data   = w_accept & wb_we_i & (w_addr == 2'd0);
  assign w_rd_data   = w_accept & ~wb_we_i & (w_addr == 2'd0);
  assign w_phase_end = (r_cnt == r_div_q);
  assign w_bit_end   = (r_state == S_HIGH) & w_phase_end;
  assign w_last      = (r_bit == 3'd7);
  assign w_rx_nx     = {r_rx[6:0], spi_sd_i};

  assign wb_data_o   = r_data_o;
  assign wb_ack_o    = r_ack;
  assign spi_cs_no   = ~r_cs_en;
  assign spi_sck_o   = r_sck;
  assign spi_sd_o    = r_tx[7];

  always_comb begin
    w_rd_mux = 8'h00;
    case (w_addr)
      2'd0: w_rd_mux = r_rx_data;
      2'd1: w_rd_mux = {6'b0, r_rx_valid, w_busy};
      2'd2: w_rd_mux = {7'b0, r_cs_en};
      2'd3: w_rd_mux = r_div;
      default: w_rd_mux = 8'h00;
    endcase
  end

  // The last high phase of bit 7 returns straight to idle; SCK is low there anyway.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_wr_data)   w_state_nx = S_SETUP;
      S_SETUP: if (w_phase_end) w_state_nx = S_HIGH;
      S_HIGH:  if (w_phase_end) w_state_nx = w_last ? S_IDLE : S_LOW;
      S_LOW:   if (w_phase_end) w_state_nx = S_HIGH;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      r_state    <= S_IDLE;
      r_sck      <= 1'b0;
      r_ack      <= 1'b0;
      r_data_o   <= 8'h00;
      r_cnt      <= 8'h00;
      r_div      <= DIV_RESET;
      r_div_q    <= DIV_RESET;
      r_tx       <= 8'h00;
      r_rx       <= 8'h00;
      r_rx_data  <= 8'h00;
      r_bit      <= 3'd0;
      r_cs_en    <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_sck    <= (w_state_nx == S_HIGH);
      r_ack    <= w_accept;
      r_data_o <= (w_accept && !wb_we_i) ? w_rd_mux : 8'h00;

      if (w_state_nx != r_state)  r_cnt <= 8'h00;
      else if (r_state != S_IDLE) r_cnt <= r_cnt + 8'd1;

      if (w_wr_data) begin
        r_tx    <= w_wdat;
        r_div_q <= r_div;
        r_bit   <= 3'd0;
      end

      // MISO is sampled at the end of each high phase; MOSI advances as SCK falls.
      if (w_bit_end) begin
        r_rx  <= w_rx_nx;
        r_bit <= r_bit + 3'd1;
        if (w_last) r_rx_data <= w_rx_nx;
        else        r_tx      <= {r_tx[6:0], 1'b0};
      end

      if (w_accept && wb_we_i && w_addr == 2'd2) r_cs_en <= w_wdat[0];
      if (w_accept && wb_we_i && w_addr == 2'd3) r_div   <= w_wdat;

      if (w_bit_end && w_last) r_rx_valid <= 1'b1;
      else if (w_rd_data)      r_rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_host.sv
// Self-checking bench for spi_host: Wishbone reads are scored against a queue of expected
// bytes, and SCK/MOSI are watched to rebuild the serial stream and high-phase widths.
module tb_spi_host;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] addr = '0;
  logic [7:0] wdat = '0;
  logic       we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic [7:0] rdat;
  logic       stall, ack, cs_n, sck, mosi, miso;

  int         cyc_cnt = 0;
  int         n_chk = 0, n_pass = 0;

  bit         rd_q[$];
  logic [7:0] d_q[$];
  string      tag_q[$];

  logic       mosi_q[$];
  int         hw_q[$];
  int         hw = 0;
  logic       prev_sck = 1'b0;

  logic       use_loop = 1'b1;
  logic [7:0] per_byte = 8'h00;
  int         per_fall = 0, per_base = 0, pidx;
  logic [7:0] per_sh;

  spi_host #(.WB_ADDR_WIDTH(4), .DATA_WIDTH(8), .DIV_RESET(8'd15)) dut (
    .wb_clock_i (clk),
    .wb_reset_ni(rst_n),
    .wb_addr_i  (addr),
    .wb_data_i  (wdat),
    .wb_data_o  (rdat),
    .wb_we_i    (we),
    .wb_cycle_i (cyc),
    .wb_strobe_i(stb),
    .wb_stall_o (stall),
    .wb_ack_o   (ack),
    .spi_cs_no  (cs_n),
    .spi_sck_o  (sck),
    .spi_sd_o   (mosi),
    .spi_sd_i   (miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Mode-0 peripheral: presents its MSB before the first rise, shifts on each fall.
  always @(negedge sck) per_fall <= per_fall + 1;
  always_comb begin
    pidx   = per_fall - per_base;
    per_sh = per_byte << pidx;
    if (use_loop)               miso = mosi;
    else if (pidx >= 0 && pidx < 8) miso = per_sh[7];
    else                        miso = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Ack scoreboard: every ack pops one request; reads compare their data.
  bit         mon_rd;
  logic [7:0] mon_d;
  string      mon_t;
  always @(negedge clk) begin
    if (ack) begin
      if (rd_q.size() == 0) chk("spurious ack", 32'd1, 32'd0);
      else begin
        mon_rd = rd_q.pop_front();
        mon_d  = d_q.pop_front();
        mon_t  = tag_q.pop_front();
        if (mon_rd) chk(mon_t, {24'd0, rdat}, {24'd0, mon_d});
      end
    end
  end

  always @(negedge clk) begin
    if (sck && !prev_sck) mosi_q.push_back(mosi);
    if (sck) hw = hw + 1;
    else if (prev_sck) begin
      hw_q.push_back(hw);
      hw = 0;
    end
    prev_sck = sck;
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic bus(input logic w, input logic [1:0] a, input logic [7:0] d,
                     input logic [7:0] e, input string tag, output int acc, output int stalls);
    rd_q.push_back(!w);
    d_q.push_back(e);
    tag_q.push_back(tag);
    we = w; addr = {2'b00, a}; wdat = d; cyc = 1'b1; stb = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (stall && stalls < 2000) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 2000) chk({tag, " stall timeout"}, 32'd1, 32'd0);
    @(posedge clk);
    #1;
    acc = cyc_cnt;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, output int acc);
    int s;
    bus(1'b1, a, d, 8'h00, "write", acc, s);
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string tag);
    int acc, s;
    bus(1'b0, a, 8'h00, e, tag, acc, s);
  endtask

  task automatic goto(input int t);
    while (cyc_cnt < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] mosi_word(input int base, input int n);
    logic [15:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[14:0], mosi_q[base + i]};
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int k, k1, k2, s1, s2, mb, hb, n2, t;

    // Reset: asserted asynchronously mid-cycle
    #12 rst_n = 1'b0;
    #1;
    chk("rst cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst sck",  {31'd0, sck},  32'd0);
    chk("rst mosi", {31'd0, mosi}, 32'd0);
    chk("rst ack",  {31'd0, ack},  32'd0);
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst rdata", {24'd0, rdat}, 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    rd(2'd1, 8'h00, "rst status");
    rd(2'd3, 8'h0F, "rst divider");

    // Loopback, DIVIDER=1
    use_loop = 1'b1;
    wr(2'd3, 8'h01, k);
    wr(2'd2, 8'h01, k);
    chk("cs asserted", {31'd0, cs_n}, 32'd0);
    mb = mosi_q.size(); hb = hw_q.size();
    wr(2'd0, 8'hA5, k);
    chk("mosi bit7 at N+1", {31'd0, mosi}, 32'd1);
    goto(k + 31);
    rd(2'd1, 8'h01, "loop busy last cycle");
    rd(2'd1, 8'h02, "loop done status");
    rd(2'd0, 8'hA5, "loop rx");
    rd(2'd1, 8'h00, "loop status cleared");
    chk("loop rises", mosi_q.size() - mb, 32'd8);
    chk("loop mosi", {16'd0, mosi_word(mb, 8)}, 32'h00A5);
    n2 = 0;
    for (int i = hb; i < hw_q.size(); i++) if (hw_q[i] == 2) n2++;
    chk("loop sck width2", n2, 32'd8);

    // Model peripheral, DIVIDER=0
    use_loop = 1'b0;
    per_byte = 8'h3C;
    per_base = per_fall;
    wr(2'd3, 8'h00, k);
    mb = mosi_q.size();
    wr(2'd0, 8'hFF, k);
    goto(k + 15);
    rd(2'd1, 8'h01, "model busy last cycle");
    rd(2'd1, 8'h02, "model done status");
    rd(2'd0, 8'h3C, "model rx");
    chk("model mosi", {16'd0, mosi_word(mb, 8)}, 32'h00FF);

    // Stall: second write waits out the first transfer
    use_loop = 1'b1;
    mb = mosi_q.size();
    bus(1'b1, 2'd0, 8'h11, 8'h00, "stall wr1", k1, s1);
    bus(1'b1, 2'd0, 8'h22, 8'h00, "stall wr2", k2, s2);
    chk("stall accept cycle", k2 - k1, 32'd17);
    chk("stall cycles", s2, 32'd16);
    goto(k2 + 16);
    rd(2'd0, 8'h22, "stall rx");
    chk("stall mosi", {16'd0, mosi_word(mb, 16)}, 32'h1122);

    // Reset after the 4th SCK rise
    wr(2'd3, 8'h01, k);
    wr(2'd2, 8'h01, k);
    mb = mosi_q.size();
    wr(2'd0, 8'h96, k);
    t = 0;
    while (mosi_q.size() < mb + 4 && t < 200) begin
      t++;
      @(negedge clk);
    end
    chk("mid 4th rise seen", {31'd0, t < 200}, 32'd1);
    #1 we = 1'b1; addr = '0; wdat = 8'h77; cyc = 1'b1; stb = 1'b1;
    #1 chk("mid stall busy", {31'd0, stall}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid rst sck", {31'd0, sck}, 32'd0);
    chk("mid rst cs_n", {31'd0, cs_n}, 32'd1);
    chk("mid rst stall", {31'd0, stall}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    rd(2'd1, 8'h00, "mid status");
    rd(2'd0, 8'h00, "mid data");
    rd(2'd3, 8'h0F, "mid divider");

    // Collision: DATA read in the completion cycle
    wr(2'd3, 8'h01, k);
    wr(2'd2, 8'h01, k);
    wr(2'd0, 8'hC3, k);
    goto(k + 32);
    rd(2'd0, 8'hC3, "coll prior rx");
    rd(2'd1, 8'h00, "coll prior cleared");
    wr(2'd0, 8'h5A, k);
    goto(k + 31);
    rd(2'd0, 8'hC3, "coll old byte");
    rd(2'd1, 8'h02, "coll valid wins");
    rd(2'd0, 8'h5A, "coll new byte");
    rd(2'd1, 8'h00, "coll status clear");
    chk("ctrl cs before", {31'd0, cs_n}, 32'd0);
    wr(2'd2, 8'h00, k);
    chk("ctrl cs at N+1", {31'd0, cs_n}, 32'd1);
    rd(2'd2, 8'h00, "ctrl readback");

    repeat (3) @(negedge clk);
    chk("acks drained", rd_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
